// File: rtl/sliced_addsub16.sv
// ============================================================================
// sliced_addsub16
//
// Purpose:
//   16-bit adder/subtractor that reuses one 4-bit carry-lookahead slice over
//   four clock cycles.
//   - Subtract is computed as A + ~B + ~cin. With this form cout = 1 means
//     "no borrow".
//   - One operation takes 5 cycles: the accepting edge, then four slice edges.
//   - From DONE, a new operation can be accepted on the very next edge, so
//     back-to-back issue is supported.
//
// Ports:
//   clk    in   1   clock; all state changes on its rising edge
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   request an operation (accepted in IDLE or DONE only)
//   A      in  16   operand A
//   B      in  16   operand B
//   cin    in   1   carry-in (add) / borrow-in (subtract)
//   sub    in   1   0 = add, 1 = subtract
//   sum    out 16   registered result, written one nibble per RUN edge
//   cout   out  1   registered carry-out (subtract: 1 = no borrow)
//   busy   out  1   high while an operation is in flight
//   done   out  1   one-cycle pulse: sum/cout valid
//   ovf    out  1   signed overflow (only with SLICED_ADDSUB_OVF_EN defined)
//
// Configuration:
//   SLICED_ADDSUB_OVF_EN  when defined, adds the ovf output and its logic.
// ============================================================================
module sliced_addsub16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        cin,
    input  logic        sub,
    output logic [15:0] sum,
    output logic        cout,
`ifdef SLICED_ADDSUB_OVF_EN
    output logic        ovf,
`endif
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_a;        // captured operand A
    logic [15:0] r_b;        // captured operand B, already inverted for subtract
    logic        r_carry;    // carry between slices
    logic [1:0]  r_cnt;      // slice index 0..3
    logic [15:0] r_sum;
    logic        r_cout;
    logic        r_busy;
    logic        r_done;
`ifdef SLICED_ADDSUB_OVF_EN
    logic        r_ovf;
`endif

    // ------------------------------------------------------------------
    // The single 4-bit carry-lookahead slice
    // ------------------------------------------------------------------
    logic [3:0] w_a;
    logic [3:0] w_b;
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;         // w_c[0] = slice carry-in, w_c[4] = slice carry-out
    logic [3:0] w_s;

    assign w_a = r_a[{r_cnt, 2'b00} +: 4];
    assign w_b = r_b[{r_cnt, 2'b00} +: 4];

    // Generate and propagate terms, plus the slice sum bits.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_gp
            assign w_g[gi] = w_a[gi] & w_b[gi];
            assign w_p[gi] = w_a[gi] ^ w_b[gi];
            assign w_s[gi] = w_p[gi] ^ w_c[gi];
        end
    endgenerate

    // Each carry is flattened from g/p and the slice carry-in.
    // Carries are not rippled from one bit to the next.
    assign w_c[0] = r_carry;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= 16'h0000;
            r_b     <= 16'h0000;
            r_carry <= 1'b0;
            r_cnt   <= 2'd0;
            r_sum   <= 16'h0000;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SLICED_ADDSUB_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B ^ {16{sub}};
                        r_carry <= cin ^ sub;
                        r_cnt   <= 2'd0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end

                RUN: begin
                    // Only the current nibble is written.
                    // Higher nibbles keep their old contents until processed.
                    r_sum[{r_cnt, 2'b00} +: 4] <= w_s;
                    r_carry <= w_c[4];
                    r_cnt   <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_cout  <= w_c[4];
`ifdef SLICED_ADDSUB_OVF_EN
                        // Carry into bit 15 differs from carry out of bit 15.
                        r_ovf   <= w_c[3] ^ w_c[4];
`endif
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign busy = r_busy;
    assign done = r_done;
`ifdef SLICED_ADDSUB_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule
